mux_nto1_arb: RTL and testbench

//   Parametrised N-to-1 multiplexer with a registered valid/ready output stage; successor to the 2-to-1 muxes.

---
 rtl/mux_arb_pkg.sv | 16 +
 rtl/mux_nto1_arb_rr_pick.sv | 50 +++++
 rtl/mux_nto1_arb.sv | 162 ++++++++++++++++
 tb/tb_mux_nto1_arb.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_arb_pkg
// Description : Shared constants for the N-to-1 arbitrated multiplexer.
//               Defines the runtime selection modes driven on the mode port.
// Revision    : 1.0  initial release
// ============================================================================
package mux_arb_pkg;

    localparam logic [1:0] MODE_MANUAL = 2'd0;  // grant the channel named by sel
    localparam logic [1:0] MODE_PRIO   = 2'd1;  // lowest-index valid channel wins
    localparam logic [1:0] MODE_RR     = 2'd2;  // rotate starting at rr_ptr
    localparam logic [1:0] MODE_RSVD   = 2'd3;  // reserved: never grants

endpackage : mux_arb_pkg
`default_nettype wire

// File: rtl/mux_nto1_arb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Rotating first-one picker. Scans req starting at index ptr,
//               wrapping N-1 -> 0, and returns the first set request.
//               With ptr = 0 it behaves as a fixed lowest-index priority pick.
// Ports       : req [N]     request vector
//               ptr [SEL_W] scan start index (expected < N)
//               gnt [N]     one-hot grant, zero when nothing requested
//               idx [SEL_W] index of the granted request (0 when none)
//               any         at least one request present
// Revision    : 1.0  initial release
// ============================================================================
module rr_pick #(
    parameter int N     = 4,
    parameter int SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [SEL_W-1:0] idx,
    output logic             any
);

    // One extra bit so ptr + offset (at most 2N-2) never overflows before
    // the wrap-around subtraction.
    logic [SEL_W:0] w_pos;

    always_comb begin
        w_pos = '0;
        gnt   = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 0; k < N; k++) begin
            w_pos = {1'b0, ptr} + (SEL_W+1)'(k);
            if (w_pos >= (SEL_W+1)'(N)) begin
                w_pos = w_pos - (SEL_W+1)'(N);
            end
            if (!any && req[w_pos[SEL_W-1:0]]) begin
                any = 1'b1;
                idx = w_pos[SEL_W-1:0];
            end
        end
        if (any) begin
            gnt[idx] = 1'b1;
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/mux_nto1_arb.sv
`default_nettype none
// ============================================================================
// Module      : mux_nto1_arb
// Description : N-to-1 multiplexer with runtime arbitration (manual select,
//               fixed priority, round-robin) feeding a registered valid/ready
//               output stage. The selected word is held with its channel
//               index until the consumer accepts it.
// Ports       : clk        clock, all state on rising edge
//               rst_n      synchronous active-low reset
//               mode [2]   0 manual, 1 priority, 2 round-robin, 3 reserved
//               sel        channel used in manual mode
//               in_valid   per-channel valid
//               in_data    channel i at bits [i*W +: W]
//               in_ready   per-channel ready (one-hot or zero)
//               o_valid    registered output valid
//               o_data     registered output word
//               o_ch       channel that supplied o_data
//               o_ready    consumer ready
// Revision    : 1.0  initial release
// ============================================================================
module mux_nto1_arb
    import mux_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int W     = 8,
    parameter int SEL_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic [SEL_W-1:0] sel,
    input  logic [N-1:0]     in_valid,
    input  logic [N*W-1:0]   in_data,
    output logic [N-1:0]     in_ready,
    output logic             o_valid,
    output logic [W-1:0]     o_data,
    output logic [SEL_W-1:0] o_ch,
    input  logic             o_ready
);

    logic             r_valid;
    logic [W-1:0]     r_data;
    logic [SEL_W-1:0] r_ch;
    logic [SEL_W-1:0] r_rr_ptr;

    logic             w_load;
    logic [N-1:0]     w_man_gnt;
    logic             w_man_any;
    logic [N-1:0]     w_prio_gnt;
    logic [SEL_W-1:0] w_prio_idx;
    logic             w_prio_any;
    logic [N-1:0]     w_rr_gnt;
    logic [SEL_W-1:0] w_rr_idx;
    logic             w_rr_any;
    logic [N-1:0]     w_gnt;
    logic [SEL_W-1:0] w_idx;
    logic             w_any;
    logic [W-1:0]     w_word;

    // The output register can accept a new word when empty or draining.
    assign w_load = ~r_valid | o_ready;

    rr_pick #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_prio_pick (
        .req (in_valid),
        .ptr ('0),
        .gnt (w_prio_gnt),
        .idx (w_prio_idx),
        .any (w_prio_any)
    );

    rr_pick #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_rr_pick (
        .req (in_valid),
        .ptr (r_rr_ptr),
        .gnt (w_rr_gnt),
        .idx (w_rr_idx),
        .any (w_rr_any)
    );

    // Manual select: a sel outside 0..N-1 (only possible when N is not a
    // power of two) grants nothing.
    always_comb begin
        w_man_gnt = '0;
        w_man_any = 1'b0;
        if (int'(sel) < N) begin
            if (in_valid[sel]) begin
                w_man_gnt[sel] = 1'b1;
                w_man_any      = 1'b1;
            end
        end
    end

    always_comb begin
        w_gnt = '0;
        w_idx = '0;
        w_any = 1'b0;
        case (mode)
            MODE_MANUAL: begin
                w_gnt = w_man_gnt;
                w_idx = sel;
                w_any = w_man_any;
            end
            MODE_PRIO: begin
                w_gnt = w_prio_gnt;
                w_idx = w_prio_idx;
                w_any = w_prio_any;
            end
            MODE_RR: begin
                w_gnt = w_rr_gnt;
                w_idx = w_rr_idx;
                w_any = w_rr_any;
            end
            default: begin
                w_gnt = '0;
                w_idx = '0;
                w_any = 1'b0;
            end
        endcase
    end

    assign in_ready = w_load ? w_gnt : '0;

    // Data select with constant part-selects keyed on the granted index.
    always_comb begin
        w_word = '0;
        for (int i = 0; i < N; i++) begin
            if (w_idx == SEL_W'(i)) begin
                w_word = in_data[i*W +: W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_ch     <= '0;
            r_rr_ptr <= '0;
        end else if (w_load) begin
            r_valid <= w_any;
            if (w_any) begin
                r_data <= w_word;
                r_ch   <= w_idx;
                // Only round-robin transfers advance the rotation pointer.
                if (mode == MODE_RR) begin
                    r_rr_ptr <= (w_idx == SEL_W'(N-1)) ? '0 : w_idx + SEL_W'(1);
                end
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_ch    = r_ch;

endmodule : mux_nto1_arb
`default_nettype wire

// File: tb/tb_mux_nto1_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_nto1_arb
// Description : Self-checking bench for mux_nto1_arb (N=4, W=8). A table of
//               directed vectors, short hand-written sequences and random
//               stimulus checked against a behavioural reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mux_nto1_arb;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int SEL_W = 2;
    localparam logic [31:0] c_data = 32'hC3A5_C1C0;

    logic             clk;
    logic             rst_n;
    logic [1:0]       mode;
    logic [SEL_W-1:0] sel;
    logic [N-1:0]     in_valid;
    logic [N*W-1:0]   in_data;
    logic [N-1:0]     in_ready;
    logic             o_valid;
    logic [W-1:0]     o_data;
    logic [SEL_W-1:0] o_ch;
    logic             o_ready;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic       m_valid = 1'b0;
    logic [7:0] m_data  = 8'h00;
    logic [1:0] m_ch    = 2'd0;
    int         m_ptr   = 0;

    typedef struct {
        logic       rst_n;
        logic [1:0] mode;
        logic [1:0] sel;
        logic [3:0] v;
        logic       ordy;
        logic [31:0] data;
        logic [3:0] e_rdy;
        logic       e_valid;
        logic [7:0] e_data;
        logic [1:0] e_ch;
    } vec_t;

    vec_t tab [24];

    mux_nto1_arb #(.N(N), .W(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mode     (mode),
        .sel      (sel),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .o_valid  (o_valid),
        .o_data   (o_data),
        .o_ch     (o_ch),
        .o_ready  (o_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic r, logic [1:0] md, logic [1:0] s, logic [3:0] v,
                                logic ordy, logic [3:0] erdy, logic ev,
                                logic [7:0] ed, logic [1:0] ec);
        vec_t t;
        t.rst_n = r; t.mode = md; t.sel = s; t.v = v; t.ordy = ordy; t.data = c_data;
        t.e_rdy = erdy; t.e_valid = ev; t.e_data = ed; t.e_ch = ec;
        return t;
    endfunction

    // Grant straight from the selection rules.
    function automatic logic [3:0] ref_grant(logic [1:0] md, logic [1:0] s,
                                             logic [3:0] v, int ptr);
        logic [3:0] g;
        bit found;
        int j;
        g = 4'b0000;
        found = 0;
        case (md)
            2'd0: if (int'(s) < N && v[s]) g[s] = 1'b1;
            2'd1: for (int i = 0; i < N; i++)
                      if (!found && v[i]) begin g[i] = 1'b1; found = 1; end
            2'd2: for (int k = 0; k < N; k++) begin
                      j = (ptr + k) % N;
                      if (!found && v[j]) begin g[j] = 1'b1; found = 1; end
                  end
            default: g = 4'b0000;
        endcase
        return g;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Inputs are applied just after a rising edge; in_ready is checked at the
    // falling edge, registered outputs 1 time unit after the next rising edge.
    task automatic run_cycle(input bit use_tab, input vec_t t);
        logic [3:0] g;
        logic [3:0] er;
        bit load;
        int idx;
        logic ev;
        rst_n    = t.rst_n;
        mode     = t.mode;
        sel      = t.sel;
        in_valid = t.v;
        in_data  = t.data;
        o_ready  = t.ordy;
        @(negedge clk);
        load = !m_valid || (o_ready == 1'b1);
        g    = ref_grant(mode, sel, in_valid, m_ptr);
        er   = load ? g : 4'b0000;
        chk("in_ready", 32'(in_ready), use_tab ? 32'(t.e_rdy) : 32'(er));
        @(posedge clk);
        #1;
        if (!t.rst_n) begin
            m_valid = 1'b0; m_data = 8'h00; m_ch = 2'd0; m_ptr = 0;
        end else if (load) begin
            m_valid = (g != 4'b0000);
            if (g != 4'b0000) begin
                idx = 0;
                for (int i = 0; i < N; i++) if (g[i]) idx = i;
                m_data = t.data[idx*8 +: 8];
                m_ch   = 2'(idx);
                if (t.mode == 2'd2) m_ptr = (idx + 1) % N;
            end
        end
        ev = use_tab ? t.e_valid : m_valid;
        chk("o_valid", 32'(o_valid), 32'(ev));
        if (ev || !t.rst_n) begin
            chk("o_data", 32'(o_data), use_tab ? 32'(t.e_data) : 32'(m_data));
            chk("o_ch",   32'(o_ch),   use_tab ? 32'(t.e_ch)   : 32'(m_ch));
        end
    endtask

    initial begin
        vec_t r;
        //           rst  mode  sel   valid    ordy  e_rdy    ev   e_data  e_ch
        tab[0]  = mk(0, 2'd3, 2'd0, 4'b1111, 0, 4'b0000, 0, 8'h00, 2'd0); // reset
        tab[1]  = mk(0, 2'd3, 2'd0, 4'b1111, 1, 4'b0000, 0, 8'h00, 2'd0);
        tab[2]  = mk(1, 2'd0, 2'd2, 4'b0100, 1, 4'b0100, 1, 8'hA5, 2'd2); // manual
        tab[3]  = mk(1, 2'd0, 2'd3, 4'b0100, 1, 4'b0000, 0, 8'h00, 2'd0);
        tab[4]  = mk(1, 2'd1, 2'd0, 4'b1010, 1, 4'b0010, 1, 8'hC1, 2'd1); // prio
        tab[5]  = mk(1, 2'd1, 2'd0, 4'b1010, 1, 4'b0010, 1, 8'hC1, 2'd1);
        tab[6]  = mk(1, 2'd2, 2'd0, 4'b1111, 1, 4'b0001, 1, 8'hC0, 2'd0); // rr
        tab[7]  = mk(1, 2'd2, 2'd0, 4'b1111, 1, 4'b0010, 1, 8'hC1, 2'd1);
        tab[8]  = mk(1, 2'd2, 2'd0, 4'b1111, 1, 4'b0100, 1, 8'hA5, 2'd2);
        tab[9]  = mk(1, 2'd2, 2'd0, 4'b1111, 1, 4'b1000, 1, 8'hC3, 2'd3);
        tab[10] = mk(1, 2'd2, 2'd0, 4'b1111, 1, 4'b0001, 1, 8'hC0, 2'd0);
        tab[11] = mk(1, 2'd2, 2'd0, 4'b1001, 1, 4'b1000, 1, 8'hC3, 2'd3);
        tab[12] = mk(1, 2'd2, 2'd0, 4'b1001, 1, 4'b0001, 1, 8'hC0, 2'd0);
        tab[13] = mk(1, 2'd2, 2'd0, 4'b1001, 1, 4'b1000, 1, 8'hC3, 2'd3);
        tab[14] = mk(1, 2'd2, 2'd0, 4'b1001, 1, 4'b0001, 1, 8'hC0, 2'd0);
        tab[15] = mk(1, 2'd2, 2'd0, 4'b1111, 0, 4'b0000, 1, 8'hC0, 2'd0); // stall
        tab[16] = mk(1, 2'd2, 2'd0, 4'b1111, 0, 4'b0000, 1, 8'hC0, 2'd0);
        tab[17] = mk(1, 2'd2, 2'd0, 4'b1111, 0, 4'b0000, 1, 8'hC0, 2'd0);
        tab[18] = mk(1, 2'd2, 2'd0, 4'b1111, 1, 4'b0010, 1, 8'hC1, 2'd1); // resume
        tab[19] = mk(1, 2'd2, 2'd0, 4'b1111, 0, 4'b0000, 1, 8'hC1, 2'd1);
        tab[20] = mk(0, 2'd2, 2'd0, 4'b1111, 0, 4'b0000, 0, 8'h00, 2'd0); // reset held word
        tab[21] = mk(1, 2'd2, 2'd0, 4'b1111, 1, 4'b0001, 1, 8'hC0, 2'd0); // rr restarts at 0
        tab[22] = mk(1, 2'd3, 2'd0, 4'b1111, 1, 4'b0000, 0, 8'h00, 2'd0); // reserved drains
        tab[23] = mk(1, 2'd2, 2'd0, 4'b0000, 1, 4'b0000, 0, 8'h00, 2'd0);

        rst_n = 1'b0; mode = 2'd3; sel = '0; in_valid = 4'b1111;
        in_data = c_data; o_ready = 1'b0;
        @(posedge clk);
        #1;

        foreach (tab[i]) run_cycle(1'b1, tab[i]);

        // in_valid drops while the output is stalled
        run_cycle(1'b0, mk(1, 2'd2, 2'd0, 4'b0100, 1, 0, 0, 0, 0));
        run_cycle(1'b0, mk(1, 2'd2, 2'd0, 4'b0100, 0, 0, 0, 0, 0));
        run_cycle(1'b0, mk(1, 2'd2, 2'd0, 4'b0000, 0, 0, 0, 0, 0));
        run_cycle(1'b0, mk(1, 2'd2, 2'd0, 4'b0000, 1, 0, 0, 0, 0));
        run_cycle(1'b0, mk(1, 2'd2, 2'd0, 4'b0001, 1, 0, 0, 0, 0));
        // mode change while a word is held
        run_cycle(1'b0, mk(1, 2'd1, 2'd0, 4'b0011, 1, 0, 0, 0, 0));
        run_cycle(1'b0, mk(1, 2'd2, 2'd0, 4'b1100, 0, 0, 0, 0, 0));
        run_cycle(1'b0, mk(1, 2'd2, 2'd0, 4'b1100, 1, 0, 0, 0, 0));

        for (int n = 0; n < 500; n++) begin
            r.rst_n = ($urandom_range(0, 39) != 0);
            r.mode  = 2'($urandom_range(0, 3));
            r.sel   = 2'($urandom_range(0, 3));
            r.v     = 4'($urandom);
            r.ordy  = ($urandom_range(0, 3) != 0);
            r.data  = $urandom;
            r.e_rdy = 4'b0000; r.e_valid = 1'b0; r.e_data = 8'h00; r.e_ch = 2'd0;
            run_cycle(1'b0, r);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mux_nto1_arb
`default_nettype wire
